pflink_rx_aligner: RTL and testbench

PFLINK_RX_ALIGNER -- requirements
Module: pflink_rx_aligner

---
 rtl/pflink_pkg.sv | 7 +
 rtl/pflink_lane_align.sv | 67 ++++++
 rtl/pflink_rx_aligner.sv | 85 ++++++++
 tb/tb_pflink_rx_aligner.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pflink_pkg.sv
// pflink_pkg: shared K-character constants and lane alignment state type
package pflink_pkg;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] PAD = 8'h1C;
  localparam logic [7:0] IDLE = 8'hF7;
  typedef enum logic {HUNT, ALIGNED} lane_state_e;
endpackage

// File: rtl/pflink_lane_align.sv
// pflink_lane_align: one receive lane -- comma alignment FSM, 32-bit word assembly, bad-cycle counter
module pflink_lane_align
  import pflink_pkg::*;
#(
  parameter logic [7:0] COMMA_K = COMMA,
  parameter logic [7:0] PAD_K = PAD
) (
  input  logic        clk_link,
  input  logic        reset,
  input  logic [15:0] rx_d,
  input  logic [1:0]  rx_k,
  input  logic [1:0]  rx_nit,
  input  logic        rx_rdy,
  input  logic        counter_reset,
  output logic [31:0] out_d,
  output logic [3:0]  out_k,
  output logic        out_v,
  output logic        lane_locked,
  output logic [31:0] bad_count
);
  lane_state_e state_q, state_d;
  logic        phase_q, phase_d;
  logic [15:0] d_prev_q;
  logic [1:0]  k_prev_q;
  logic [31:0] out_d_q, cnt_q;
  logic [3:0]  out_k_q;
  logic        out_v_q, locked_q;
  logic        ok, comma, emit;
  // decode the current half and decide the next alignment state; phase 0 is the comma half
  always_comb begin
    ok = ~|rx_nit && rx_rdy;
    comma = (rx_k == 2'b01) && (rx_d[7:0] == COMMA_K);
    emit = (state_q == ALIGNED) && phase_q && ok && !comma;
    state_d = (state_q == HUNT) ? ((comma && ok) ? ALIGNED : HUNT)
                                : ((!ok || (comma && phase_q)) ? HUNT : ALIGNED);
    phase_d = (state_d == ALIGNED) && ((state_q == HUNT) ? 1'b1 : !phase_q);
  end
  // lane state, registered word output, lock flag and saturating bad counter
  always_ff @(posedge clk_link or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      phase_q <= 1'b0;
      d_prev_q <= '0;
      k_prev_q <= '0;
      out_d_q <= {4{PAD_K}};
      out_k_q <= 4'hF;
      out_v_q <= 1'b0;
      locked_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      d_prev_q <= rx_d;
      k_prev_q <= rx_k;
      out_d_q <= emit ? {rx_d, d_prev_q} : {4{PAD_K}};
      out_k_q <= emit ? {rx_k, k_prev_q} : 4'hF;
      out_v_q <= emit;
      locked_q <= (state_q == ALIGNED);
      cnt_q <= counter_reset ? '0 : (!ok && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end
  end
  assign out_d = out_d_q;
  assign out_k = out_k_q;
  assign out_v = out_v_q;
  assign lane_locked = locked_q;
  assign bad_count = cnt_q;
endmodule

// File: rtl/pflink_rx_aligner.sv
// pflink_rx_aligner: multi-lane GT receive word aligner with optional spy capture (PFLINK_RX_SPY_EN)
module pflink_rx_aligner #(
  parameter int NUM_LANES = 2,
  parameter int SPY_DEPTH = 64,
  parameter logic [7:0] COMMA = pflink_pkg::COMMA,
  parameter logic [7:0] PAD = pflink_pkg::PAD,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int AW = $clog2(SPY_DEPTH)
) (
  input  logic                    clk_link,
  input  logic                    reset,
  input  logic [16*NUM_LANES-1:0] rx_d,
  input  logic [2*NUM_LANES-1:0]  rx_k,
  input  logic [2*NUM_LANES-1:0]  rx_nit,
  input  logic [NUM_LANES-1:0]    rx_rdy,
  input  logic                    counter_reset,
  output logic [32*NUM_LANES-1:0] out_d,
  output logic [4*NUM_LANES-1:0]  out_k,
  output logic [NUM_LANES-1:0]    out_v,
  output logic [NUM_LANES-1:0]    lane_locked,
  output logic [32*NUM_LANES-1:0] bad_count,
  input  logic                    spy_start,
  input  logic [LW-1:0]           spy_lane,
  input  logic [AW-1:0]           spy_raddr,
  output logic [31:0]             spy_rdata,
  output logic                    spy_done
);
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    pflink_lane_align #(.COMMA_K(COMMA), .PAD_K(PAD)) u_lane (
      .clk_link(clk_link),
      .reset(reset),
      .rx_d(rx_d[16*n +: 16]),
      .rx_k(rx_k[2*n +: 2]),
      .rx_nit(rx_nit[2*n +: 2]),
      .rx_rdy(rx_rdy[n]),
      .counter_reset(counter_reset),
      .out_d(out_d[32*n +: 32]),
      .out_k(out_k[4*n +: 4]),
      .out_v(out_v[n]),
      .lane_locked(lane_locked[n]),
      .bad_count(bad_count[32*n +: 32])
    );
  end
`ifdef PFLINK_RX_SPY_EN
  logic [31:0] spy_word [NUM_LANES];
  logic [31:0] mem [SPY_DEPTH];
  logic [31:0] rdata_q;
  logic [AW-1:0] ptr_q;
  logic [LW-1:0] lane_q;
  logic act_q, done_q;
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_spy
    assign spy_word[n] = {12'h0, rx_nit[2*n +: 2], rx_k[2*n +: 2], rx_d[16*n +: 16]};
  end
  // capture control: a start (even mid-capture) rewinds the pointer and relatches the lane
  always_ff @(posedge clk_link or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      lane_q <= '0;
      act_q <= 1'b0;
      done_q <= 1'b0;
    end else if (spy_start) begin
      ptr_q <= '0;
      lane_q <= spy_lane;
      act_q <= 1'b1;
      done_q <= 1'b0;
    end else if (act_q) begin
      ptr_q <= ptr_q + 1'b1;
      act_q <= (ptr_q != AW'(SPY_DEPTH - 1));
      done_q <= (ptr_q == AW'(SPY_DEPTH - 1));
    end
  end
  // capture RAM with registered read port
  always_ff @(posedge clk_link) begin
    if (act_q && !spy_start) mem[ptr_q] <= spy_word[lane_q];
    rdata_q <= mem[spy_raddr];
  end
  assign spy_rdata = rdata_q;
  assign spy_done = done_q;
`else
  logic unused_spy;
  assign unused_spy = ^{spy_start, spy_lane, spy_raddr};
  assign spy_rdata = '0;
  assign spy_done = 1'b0;
`endif
endmodule

// File: tb/tb_pflink_rx_aligner.sv
// tb_pflink_rx_aligner: randomized scoreboard bench for pflink_rx_aligner
module tb_pflink_rx_aligner;
  localparam int NL = 2;
  logic clk_link = 0, reset = 1, counter_reset = 0, spy_start = 0;
  logic [16*NL-1:0] rx_d = '0;
  logic [2*NL-1:0] rx_k = '0, rx_nit = '0;
  logic [NL-1:0] rx_rdy = '1;
  logic [0:0] spy_lane = '0;
  logic [5:0] spy_raddr = '0;
  logic [32*NL-1:0] out_d, bad_count;
  logic [4*NL-1:0] out_k;
  logic [NL-1:0] out_v, lane_locked;
  logic [31:0] spy_rdata;
  logic spy_done;

  pflink_rx_aligner #(.NUM_LANES(NL), .SPY_DEPTH(64)) dut (
    .clk_link(clk_link), .reset(reset), .rx_d(rx_d), .rx_k(rx_k), .rx_nit(rx_nit),
    .rx_rdy(rx_rdy), .counter_reset(counter_reset), .out_d(out_d), .out_k(out_k),
    .out_v(out_v), .lane_locked(lane_locked), .bad_count(bad_count), .spy_start(spy_start),
    .spy_lane(spy_lane), .spy_raddr(spy_raddr), .spy_rdata(spy_rdata), .spy_done(spy_done)
  );

  always #5 clk_link = ~clk_link;

  typedef struct packed {
    logic [NL-1:0] v;
    logic [NL-1:0] lk;
    logic [NL-1:0][31:0] bad;
  } rec_t;

  int n_chk = 0, n_fail = 0;
  rec_t exp_q[$];
  logic [35:0] wq [NL][$];

  // stimulus for the next cycle
  logic [15:0] s_d [NL];
  logic [1:0] s_k [NL], s_nit [NL];
  logic s_rdy [NL];
  logic s_rst = 1, s_cr = 0, s_spy = 0, s_force = 0;
  logic [0:0] s_spy_lane = '0;
  logic [5:0] s_raddr = '0;

  // reference model: alignment status, half-word phase, previous half, bad count
  logic m_lock [NL], m_ph [NL];
  logic [15:0] m_pd [NL];
  logic [1:0] m_pk [NL];
  logic [31:0] m_bad [NL];

  logic [31:0] cap_arr [64];
  int cap_i = 0;
  logic cap_arm = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    rec_t r;
    logic ok, cm;
    @(posedge clk_link);
    #2;
    reset = s_rst;
    counter_reset = s_cr;
    spy_start = s_spy;
    spy_lane = s_spy_lane;
    spy_raddr = s_raddr;
    for (int n = 0; n < NL; n++) begin
      rx_d[16*n +: 16] = s_d[n];
      rx_k[2*n +: 2] = s_k[n];
      rx_nit[2*n +: 2] = s_nit[n];
      rx_rdy[n] = s_rdy[n];
    end
    if (s_force) begin
      dut.g_lane[0].u_lane.cnt_q = 32'hFFFF_FFFE;
      m_bad[0] = 32'hFFFF_FFFE;
      s_force = 0;
    end
    if (cap_arm && cap_i < 64) begin
      cap_arr[cap_i] = {12'h0, s_nit[1], s_k[1], s_d[1]};
      cap_i++;
    end
    if (s_spy) begin
      cap_arm = 1;
      cap_i = 0;
    end
    for (int n = 0; n < NL; n++) begin
      if (s_rst) begin
        m_lock[n] = 0;
        m_ph[n] = 0;
        m_bad[n] = 0;
        r.v[n] = 0;
        r.lk[n] = 0;
        r.bad[n] = 0;
      end else begin
        ok = (s_nit[n] == 2'b00) && s_rdy[n];
        cm = (s_k[n] == 2'b01) && (s_d[n][7:0] == 8'hBC);
        r.lk[n] = m_lock[n];
        r.v[n] = m_lock[n] && m_ph[n] && ok && !cm;
        if (r.v[n]) wq[n].push_back({s_k[n], m_pk[n], s_d[n], m_pd[n]});
        if (!m_lock[n]) begin
          if (cm && ok) begin
            m_lock[n] = 1;
            m_ph[n] = 1;
          end
        end else if (!ok || (cm && m_ph[n])) m_lock[n] = 0;
        else m_ph[n] = !m_ph[n];
        if (s_cr) m_bad[n] = 0;
        else if (!ok && m_bad[n] != 32'hFFFF_FFFF) m_bad[n] = m_bad[n] + 1;
        r.bad[n] = m_bad[n];
      end
      m_pd[n] = s_d[n];
      m_pk[n] = s_k[n];
    end
    exp_q.push_back(r);
  endtask

  task automatic set_lane(input int n, input logic [15:0] d, input logic [1:0] k,
                          input logic [1:0] nit, input logic rdy);
    s_d[n] = d;
    s_k[n] = k;
    s_nit[n] = nit;
    s_rdy[n] = rdy;
  endtask

  task automatic rand_lane(input int n);
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) set_lane(n, {8'($urandom), 8'hBC}, 2'b01, 2'b00, 1'b1);
    else if (r < 35) set_lane(n, 16'($urandom), 2'b01, 2'b00, 1'b1);
    else if (r < 42) set_lane(n, 16'($urandom), 2'($urandom), 2'($urandom_range(1, 3)), 1'b1);
    else if (r < 45) set_lane(n, 16'($urandom), 2'b00, 2'b00, 1'b0);
    else set_lane(n, 16'($urandom), 2'($urandom_range(0, 2)) & 2'b10, 2'b00, 1'b1);
  endtask

  // monitor: compares every cycle's outputs against the prediction made one cycle earlier
  initial begin
    rec_t r;
    logic [35:0] w;
    forever begin
      @(posedge clk_link);
      #1;
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        for (int n = 0; n < NL; n++) begin
          chk($sformatf("out_v[%0d]", n), 64'(out_v[n]), 64'(r.v[n]));
          if (out_v[n]) begin
            if (wq[n].size() == 0) chk($sformatf("unexpected_word[%0d]", n), 64'(out_d[32*n +: 32]), 64'hX);
            else begin
              w = wq[n].pop_front();
              chk($sformatf("word_d[%0d]", n), 64'(out_d[32*n +: 32]), 64'(w[31:0]));
              chk($sformatf("word_k[%0d]", n), 64'(out_k[4*n +: 4]), 64'(w[35:32]));
            end
          end else begin
            chk($sformatf("pad_d[%0d]", n), 64'(out_d[32*n +: 32]), 64'h1C1C1C1C);
            chk($sformatf("pad_k[%0d]", n), 64'(out_k[4*n +: 4]), 64'hF);
          end
          chk($sformatf("locked[%0d]", n), 64'(lane_locked[n]), 64'(r.lk[n]));
          chk($sformatf("bad[%0d]", n), 64'(bad_count[32*n +: 32]), 64'(r.bad[n]));
        end
`ifndef PFLINK_RX_SPY_EN
        chk("spy_rdata_off", 64'(spy_rdata), 64'h0);
        chk("spy_done_off", 64'(spy_done), 64'h0);
`endif
      end
    end
  end

  initial begin
    for (int n = 0; n < NL; n++) set_lane(n, 16'h0, 2'b00, 2'b00, 1'b1);
    repeat (3) @(posedge clk_link);
    #1;
    chk("rst_out_v", 64'(out_v), 64'h0);
    chk("rst_out_d", 64'(out_d), {2{32'h1C1C1C1C}});
    chk("rst_out_k", 64'(out_k), 64'hFF);
    chk("rst_locked", 64'(lane_locked), 64'h0);
    chk("rst_bad", 64'(bad_count), 64'h0);
    chk("rst_spy_done", 64'(spy_done), 64'h0);
    s_rst = 0;
    step();
    // lane 0 locks on a comma and assembles its first word
    set_lane(0, 16'h12BC, 2'b01, 2'b00, 1'b1);
    set_lane(1, 16'h0001, 2'b00, 2'b00, 1'b1);
    step();
    set_lane(0, 16'h5678, 2'b00, 2'b00, 1'b1);
    step();
    set_lane(0, 16'h1111, 2'b00, 2'b00, 1'b1);
    step();
    chk("first_word_d", 64'(out_d[31:0]), 64'h567812BC);
    chk("first_word_k", 64'(out_k[3:0]), 64'h1);
    chk("first_word_v", 64'(out_v[0]), 64'h1);
    chk("first_word_lock", 64'(lane_locked[0]), 64'h1);
    // comma at phase 1 breaks lock; a later comma relocks
    set_lane(0, 16'h34BC, 2'b01, 2'b00, 1'b1);
    step();
    set_lane(0, 16'h2222, 2'b00, 2'b00, 1'b1);
    step();
    step();
    chk("unlock_after_phase1_comma", 64'(lane_locked[0]), 64'h0);
    set_lane(0, 16'h56BC, 2'b01, 2'b00, 1'b1);
    step();
    set_lane(0, 16'h9ABC, 2'b00, 2'b00, 1'b1);
    step();
    // five not-in-table cycles on lane 1 only
    set_lane(1, 16'h3333, 2'b00, 2'b10, 1'b1);
    repeat (5) step();
    set_lane(1, 16'h3333, 2'b00, 2'b00, 1'b1);
    step();
    chk("bad1_five", 64'(bad_count[63:32]), 64'd5);
    chk("bad0_clean", 64'(bad_count[31:0]), 64'd0);
    set_lane(1, 16'h3333, 2'b00, 2'b10, 1'b1);
    s_cr = 1;
    step();
    s_cr = 0;
    set_lane(1, 16'h3333, 2'b00, 2'b00, 1'b1);
    step();
    chk("cr_wins", 64'(bad_count[63:32]), 64'd0);
    // saturation near the top of the counter
    s_force = 1;
    set_lane(0, 16'h4444, 2'b00, 2'b00, 1'b0);
    repeat (3) step();
    set_lane(0, 16'h4444, 2'b00, 2'b00, 1'b1);
    step();
    chk("bad0_saturate", 64'(bad_count[31:0]), 64'hFFFF_FFFF);
    // reset between the two halves of a word
    s_cr = 1;
    step();
    s_cr = 0;
    set_lane(0, 16'hAABC, 2'b01, 2'b00, 1'b1);
    step();
    set_lane(0, 16'h5555, 2'b00, 2'b00, 1'b1);
    s_rst = 1;
    step();
    chk("midword_rst_d", 64'(out_d[31:0]), 64'h1C1C1C1C);
    chk("midword_rst_v", 64'(out_v), 64'h0);
    chk("midword_rst_bad", 64'(bad_count), 64'h0);
    s_rst = 0;
    set_lane(0, 16'h6666, 2'b00, 2'b00, 1'b1);
    repeat (3) step();
    // randomized traffic with occasional counter clears and resets
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < NL; n++) rand_lane(n);
      s_cr = ($urandom_range(0, 99) < 2);
      s_rst = ($urandom_range(0, 199) < 2);
      step();
    end
    s_cr = 0;
    s_rst = 0;
`ifdef PFLINK_RX_SPY_EN
    s_spy = 1;
    s_spy_lane = 1'b1;
    step();
    s_spy = 0;
    begin
      int t;
      t = 0;
      while (!spy_done && t < 100) begin
        for (int n = 0; n < NL; n++) rand_lane(n);
        step();
        t++;
      end
      chk("spy_done", 64'(spy_done), 64'h1);
    end
    for (int a = 0; a < 4; a++) begin
      s_raddr = 6'(a);
      step();
      step();
      chk($sformatf("spy_rdata[%0d]", a), 64'(spy_rdata), 64'(cap_arr[a]));
    end
`endif
    for (int n = 0; n < NL; n++) set_lane(n, 16'h0, 2'b00, 2'b00, 1'b1);
    repeat (3) step();
    repeat (2) @(posedge clk_link);
    #2;
    for (int n = 0; n < NL; n++) chk($sformatf("leftover_words[%0d]", n), 64'(wq[n].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
